// File: rtl/collect_shared_bv_pkg.sv
// Shared types and constants for the half-to-full shared-bitvector collector.
// Optional macro COLLECT_SHARED_CLEAR_EN is consumed by the files that import this package.
package collect_shared_bv_pkg;

    localparam int DEF_NUM_SHARES = 2;
    localparam int DEF_HALF_WIDTH = 15;
    localparam int DEF_BIT_WIDTH  = 2 * DEF_HALF_WIDTH;

    typedef logic [DEF_NUM_SHARES-1:0][DEF_HALF_WIDTH-1:0] shared_half_t;
    typedef logic [DEF_NUM_SHARES-1:0][DEF_BIT_WIDTH-1:0]  shared_full_t;

    // LO: waiting for a low half; HI: low half held, next half completes the word
    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } state_t;

endpackage

// File: rtl/collect_shared_bv_reg.sv
// Enable/clear register for a shared vector; load wins over clear.
// Used for both the low-half holding register and the output register.
module shared_bv_reg #(
    parameter int NUM_SHARES = 2,
    parameter int WIDTH      = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                clr,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]    d,
    output logic [NUM_SHARES-1:0][WIDTH-1:0]    q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
        else if (clr)
            q <= '0;
    end

endmodule

// File: rtl/collect_shared_bv.sv
// Collects low then high half-width shared words into one full-width shared word.
// Define COLLECT_SHARED_CLEAR_EN to zero consumed share data and mask out_a when idle.
module collect_shared_bv
    import collect_shared_bv_pkg::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES,
    parameter int HALF_WIDTH = DEF_HALF_WIDTH
) (
    input  logic                                    in_clock,
    input  logic                                    in_reset,
    input  logic                                    in_valid,
    output logic                                    out_ready,
    input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   in_half,
    output logic                                    out_expect_hi,
    output logic                                    out_valid,
    input  logic                                    in_ready,
    output logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0] out_a
);

    localparam int BIT_WIDTH = 2 * HALF_WIDTH;

    state_t state;
    logic   out_full;
    logic   up_xfer, lo_xfer, hi_xfer, down_xfer;
    logic   lo_clr, out_clr;

    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] lo_q;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  full_d, out_q;

    // A full output slot may drain and refill on the same edge
    assign out_ready     = (state == ST_LO) || !out_full || in_ready;
    assign out_expect_hi = (state == ST_HI);
    assign out_valid     = out_full;

    assign up_xfer   = in_valid && out_ready;
    assign lo_xfer   = up_xfer && (state == ST_LO);
    assign hi_xfer   = up_xfer && (state == ST_HI);
    assign down_xfer = out_full && in_ready;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state    <= ST_LO;
            out_full <= 1'b0;
        end else begin
            if (lo_xfer)
                state <= ST_HI;
            else if (hi_xfer)
                state <= ST_LO;
            if (hi_xfer)
                out_full <= 1'b1;
            else if (down_xfer)
                out_full <= 1'b0;
        end
    end

    // Each share is assembled only from its own halves
    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_join
        assign full_d[i] = {in_half[i], lo_q[i]};
    end

`ifdef COLLECT_SHARED_CLEAR_EN
    assign lo_clr  = hi_xfer;
    assign out_clr = down_xfer && !hi_xfer;
    assign out_a   = out_full ? out_q : '0;
`else
    assign lo_clr  = 1'b0;
    assign out_clr = 1'b0;
    assign out_a   = out_q;
`endif

    shared_bv_reg #(.NUM_SHARES(NUM_SHARES), .WIDTH(HALF_WIDTH)) u_lo_reg (
        .clk (in_clock),
        .rst (in_reset),
        .en  (lo_xfer),
        .clr (lo_clr),
        .d   (in_half),
        .q   (lo_q)
    );

    shared_bv_reg #(.NUM_SHARES(NUM_SHARES), .WIDTH(BIT_WIDTH)) u_out_reg (
        .clk (in_clock),
        .rst (in_reset),
        .en  (hi_xfer),
        .clr (out_clr),
        .d   (full_d),
        .q   (out_q)
    );

endmodule

// File: tb/tb_collect_shared_bv.sv
// Directed plus randomized check of collect_shared_bv against a queue-based model.
// Honours COLLECT_SHARED_CLEAR_EN for the expected idle value of out_a.
module tb_collect_shared_bv;

    localparam int NS = 2;
    localparam int HW = 15;
    localparam int BW = 2 * HW;

    typedef logic [NS-1:0][HW-1:0] half_t;
    typedef logic [NS-1:0][BW-1:0] word_t;

    logic  in_clock = 1'b0;
    logic  in_reset, in_valid, in_ready;
    half_t in_half;
    logic  out_ready, out_expect_hi, out_valid;
    word_t out_a;

    int vectors = 0;
    int miscompares = 0;

    half_t halves[$];
    word_t words[$];
    word_t last_word;

    collect_shared_bv #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_half       (in_half),
        .out_expect_hi (out_expect_hi),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_a         (out_a)
    );

    always #5 in_clock = ~in_clock;

    function automatic word_t join_halves(input half_t lo, input half_t hi);
        word_t w;
        for (int i = 0; i < NS; i++)
            w[i] = (BW'(hi[i]) << HW) | BW'(lo[i]);
        return w;
    endfunction

    function automatic half_t rand_half();
        half_t h;
        for (int i = 0; i < NS; i++)
            h[i] = HW'($urandom);
        return h;
    endfunction

    function automatic word_t idle_word();
`ifdef COLLECT_SHARED_CLEAR_EN
        return '0;
`else
        return last_word;
`endif
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input word_t obs, input word_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check before posedge, update model at posedge.
    task automatic cycle(input logic v, input half_t h, input logic r);
        logic exp_ready, up, down;
        word_t w;
        in_valid = v;
        in_half  = h;
        in_ready = r;
        #1;
        exp_ready = (halves.size() == 0) || (words.size() == 0) || r;
        check_bit("out_ready", out_ready, exp_ready);
        check_bit("out_expect_hi", out_expect_hi, halves.size() == 1);
        check_bit("out_valid", out_valid, words.size() != 0);
        if (words.size() != 0)
            check_word("out_a", out_a, words[0]);
        else
            check_word("out_a_idle", out_a, idle_word());
        up   = v && exp_ready;
        down = (words.size() != 0) && r;
        @(posedge in_clock);
        if (down)
            void'(words.pop_front());
        if (up) begin
            halves.push_back(h);
            if (halves.size() == 2) begin
                w = join_halves(halves[0], halves[1]);
                halves.delete();
                words.push_back(w);
                last_word = w;
            end
        end
        @(negedge in_clock);
    endtask

    initial begin
        half_t lo, hi;
        word_t bw;

        last_word = '0;
        in_reset  = 1'b1;
        in_valid  = 1'b0;
        in_ready  = 1'b0;
        in_half   = '0;
        #2;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_expect_hi", out_expect_hi, 1'b0);
        check_bit("rst_out_ready", out_ready, 1'b1);
        check_word("rst_out_a", out_a, '0);
        @(negedge in_clock);
        in_reset = 1'b0;

        // Basic pair with known values
        lo[0] = 15'h0ABC; lo[1] = 15'h1234;
        hi[0] = 15'h0001; hi[1] = 15'h7FFF;
        cycle(1'b1, lo, 1'b1);
        cycle(1'b1, hi, 1'b1);
        bw[0] = 30'h0000_8ABC;
        bw[1] = {15'h7FFF, 15'h1234};
        #1;
        check_bit("basic_valid", out_valid, 1'b1);
        check_word("basic_word", out_a, bw);
        cycle(1'b0, rand_half(), 1'b1);
        cycle(1'b0, rand_half(), 1'b1);

        // Backpressure: low half accepted while full, high half stalls, then handoff
        cycle(1'b1, rand_half(), 1'b0);
        cycle(1'b1, rand_half(), 1'b0);
        cycle(1'b1, rand_half(), 1'b0);
        hi = rand_half();
        for (int k = 0; k < 3; k++)
            cycle(1'b1, hi, 1'b0);
        cycle(1'b1, hi, 1'b1);
        cycle(1'b0, rand_half(), 1'b0);
        cycle(1'b0, rand_half(), 1'b1);
        cycle(1'b0, rand_half(), 1'b1);

        // Streaming: 8 back-to-back halves
        for (int k = 0; k < 8; k++)
            cycle(1'b1, rand_half(), 1'b1);
        cycle(1'b0, rand_half(), 1'b1);
        cycle(1'b0, rand_half(), 1'b1);

        // Reset asserted between edges while a low half is held
        cycle(1'b1, rand_half(), 1'b1);
        in_valid = 1'b0;
        #2 in_reset = 1'b1;
        #1;
        check_bit("midrst_expect_hi", out_expect_hi, 1'b0);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_word("midrst_out_a", out_a, '0);
        halves.delete();
        words.delete();
        last_word = '0;
        #1 in_reset = 1'b0;
        @(negedge in_clock);
        lo = rand_half();
        hi = rand_half();
        cycle(1'b1, lo, 1'b1);
        cycle(1'b1, hi, 1'b1);
        cycle(1'b0, rand_half(), 1'b1);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 3) != 0), rand_half(), 1'($urandom_range(0, 2) != 0));
        for (int k = 0; k < 3; k++)
            cycle(1'b0, rand_half(), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collect_shared_bv.md
Name: collect_shared_bv

Overview:
- Sequential inverse of the shared-bitvector half splitter.
- Accepts one half-width shared word per transfer, low half first, then high half.
- Reassembles each pair into a full-width shared bitvector and presents it downstream under valid/ready.
- Sits between half-width masked datapath stages (e.g. split S-box halves) and full-width consumers; share domains are never combined.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per value.
- HALF_WIDTH, 15, bits per half; BIT_WIDTH = 2*HALF_WIDTH (localparam).

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream half word valid.
- out_ready  output  1  block can accept a half this cycle.
- in_half  input  [NUM_SHARES-1:0][HALF_WIDTH-1:0]  shared half word.
- out_expect_hi  output  1  next accepted half is treated as the high half.
- out_valid  output  1  assembled word valid.
- in_ready  input  1  downstream accepts the word.
- out_a  output  [NUM_SHARES-1:0][BIT_WIDTH-1:0]  assembled shared word.

Behaviour:
- Interface: one clock, in_clock; reset in_reset is asynchronous and active-high.
- Storage:
  - lo_q: low-half register, with flag lo_full.
  - out_q: output register, with flag out_full.
- Reset values: lo_full=0, out_full=0, lo_q=0, out_q=0. Resulting outputs: out_valid=0, out_expect_hi=0, out_ready=1, out_a=0.
- Reset asserted mid-pair: the held low half is discarded and the next accepted half is treated as low.
- Handshakes:
  - Upstream transfer: in_valid && out_ready on a rising edge.
  - Downstream transfer: out_valid && in_ready.
- State machine (on lo_full): LO (lo_full=0) and HI (lo_full=1). out_expect_hi = lo_full.
- out_ready:
  - LO: out_ready=1.
  - HI: out_ready = !out_full || in_ready, so a full output slot may be consumed and refilled in the same cycle.
- Transfer in LO: lo_q <= in_half; go to HI.
- Transfer in HI:
  - For every share i: out_q[i] <= {in_half[i], lo_q[i]} (low half at bits [HALF_WIDTH-1:0]).
  - out_full <= 1; go to LO.
- Downstream transfer with no simultaneous HI transfer: out_full <= 0.
- Simultaneous downstream transfer and HI transfer: out_full stays 1 and out_q takes the new word.
- Low half accepted while out_full=1: allowed. No stall occurs until the high half arrives.
- Latency: assembled word is visible on out_a one cycle after the high-half transfer.
- Throughput: one word per two upstream transfers. No combinational path from in_half to out_a.
- out_valid = out_full; out_a = out_q.
- Shares are bit-exact: share i of the output depends only on share i of the inputs. No randomness and no cross-share logic.
- in_half is ignored whenever no upstream transfer occurs.

Optional Feature:
- Macro: COLLECT_SHARED_CLEAR_EN.
- Defined (share-data hygiene for side-channel security):
  - lo_q is cleared to 0 on the cycle the high-half transfer consumes it.
  - out_q is cleared to 0 on a downstream transfer not coinciding with a HI transfer.
  - out_a is forced to 0 whenever out_valid=0.
- Undefined: data registers keep stale contents; out_a = out_q unconditionally.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package holds:
  - typedefs for the shared half vector and shared full vector, parameterised by NUM_SHARES and HALF_WIDTH;
  - a constant for the default HALF_WIDTH (15);
  - the LO/HI state enum.
- One natural sub-module: shared_bv_reg, an enable/clear register for a shared vector with asynchronous active-high reset. It is instantiated for lo_q and out_q; its clear input is tied to 0 unless COLLECT_SHARED_CLEAR_EN is defined.

Test Plan:
- Basic pair (NUM_SHARES=2, HALF_WIDTH=15):
  - Stimulus: in_ready=1; send lo = {share1 15'h1234, share0 15'h0ABC}, then hi = {15'h7FFF, 15'h0001}.
  - Response: one cycle later out_valid=1, out_a[0]=30'h0000_8ABC i.e. {15'h0001,15'h0ABC}, out_a[1]={15'h7FFF,15'h1234}.
- Backpressure:
  - Stimulus: in_ready=0; complete one pair, send a second low half.
  - Response: low half is accepted, out_expect_hi=1, out_ready=0. Holding the second high half valid stalls with out_a unchanged. When in_ready goes to 1, the same-cycle handoff occurs and the next cycle shows the new word with out_valid still 1.
- Streaming: in_valid=1 and in_ready=1 continuously for 8 halves → 4 words, out_valid pulses every 2nd cycle, order preserved.
- Reset mid-pair:
  - Stimulus: accept a low half, assert in_reset asynchronously between clock edges.
  - Response: out_expect_hi=0, out_valid=0, out_a=0 immediately. The next half is treated as low.
- COLLECT_SHARED_CLEAR_EN build:
  - After each word is consumed, out_a reads 0 while out_valid=0.
  - The internal lo_q is 0 after each high-half transfer.
  - In the non-macro build, out_a holds the last word.
